br_redirect_ctrl: RTL and testbench
===================================

// Module: br_redirect_ctrl
// PURPOSE
//  Sequences the branch-resolution outcome of the EXE stage into a front-end redirect. Compares the
//  actual next PC (br_pc / no_br_pc from the branch functional unit) against the PC fetch predicted.
//  On mismatch it issues a held redirect to fetch (valid/ack), flushes younger IF/ID work for a set
//  number of cycles, and holds EXE meanwhile. Misaligned targets are reported as an exception, not redirected.
// PARAMETERS
//  PC_SZ      32  PC width
//  FLUSH_CYC  2   flush cycles after redirect ack (0..15; 0 = no flush phase)
//  CNT_SZ     32  perf counter width (BR_PERF_EN only)
// PORTS
//  clk_in            in   1      clock, rising edge
//  reset_in          in   1      asynchronous, active-low reset
//  exe_valid_in      in   1      EXE presents a resolved branch/jump/xRET this cycle
//  br_taken_in       in   1      branch FU taken result
//  br_pc_in          in   PC_SZ  branch FU target PC
//  no_br_pc_in       in   PC_SZ  branch FU fall-through PC (PC+2/PC+4)
//  mis_in            in   1      branch FU target-misaligned flag (tie 0 when ext_C)
//  pred_pc_in        in   PC_SZ  next PC that fetch actually followed for this instruction
//  kill_in           in   1      trap/pipeline kill from CSR/WB; aborts any redirect activity
//  redirect_ack_in   in   1      fetch accepted redirect this cycle
//  redirect_valid_out out 1      redirect request to fetch
//  redirect_pc_out   out  PC_SZ  redirect target, stable while redirect_valid_out=1
//  flush_out         out  1      discard all IF/ID instructions younger than the branch
//  exe_hold_out      out  1      stall EXE; no new exe_valid_in accepted
//  misalign_exc_out  out  1      one-cycle pulse: taken target misaligned
//  misalign_addr_out out  PC_SZ  offending target (held until next pulse)
// BEHAVIOUR
//  - actual_pc = br_taken_in ? br_pc_in : no_br_pc_in; mispred = (actual_pc != pred_pc_in), full PC_SZ compare.
//  - All outputs registered. Reset: state=IDLE, every output 0, counters 0.
//  - FSM IDLE / REDIRECT / FLUSH. exe_hold_out = (state != IDLE). exe_valid_in ignored unless IDLE.
//  - IDLE, exe_valid_in & mis_in & br_taken_in: next cycle misalign_exc_out=1 for 1 cycle,
//    misalign_addr_out=br_pc_in; stay IDLE; no redirect (exception priority over mispredict).
//  - IDLE, exe_valid_in & mispred & !(mis_in & br_taken_in): latch redirect_pc_out=actual_pc; next cycle
//    redirect_valid_out=1, flush_out=1, state=REDIRECT (latency 1 cycle from resolution).
//  - IDLE, exe_valid_in & !mispred: no action (correct prediction).
//  - REDIRECT: hold valid/pc/flush until redirect_ack_in=1 sampled; then drop redirect_valid_out;
//    FLUSH_CYC>0 -> FLUSH with cnt=FLUSH_CYC; FLUSH_CYC=0 -> IDLE, flush_out=0.
//  - FLUSH: flush_out=1; cnt decrements each cycle; when cnt==1 -> IDLE next cycle, flush_out=0.
//    Total flush_out high = cycles in REDIRECT + FLUSH_CYC.
//  - kill_in=1 (any state): next cycle IDLE, redirect_valid_out/flush_out/exe_hold_out=0; kill beats a
//    simultaneous mispredict, misalign, or ack in the same cycle (no perf increment for that cycle).
//  - redirect_ack_in while not in REDIRECT: ignored.
//  - Reset asserted mid-operation: immediate return to IDLE, outputs 0; no redirect resumes after release.
// CONFIGURATION
//  BR_PERF_EN defined: adds clr_cnt_in (in 1), br_cnt_out, mispred_cnt_out (out CNT_SZ).
//    br_cnt_out +1 per exe_valid_in accepted in IDLE; mispred_cnt_out +1 per REDIRECT entry.
//    Both saturate at all-ones; clr_cnt_in synchronous clear, priority over increment; kill_in cycle: no count.
//  BR_PERF_EN undefined: ports and counters absent; control behaviour identical.
// TESTING
//  1 beq taken, br_pc=0x100, pred_pc=0x100 -> no redirect, no flush, exe_hold_out stays 0.
//  2 bne taken, br_pc=0x200, pred_pc=0x44; ack 3 cycles later -> valid+pc=0x200 cycle+1, held until ack,
//    flush_out high 3+2=5 cycles, exe_hold_out high throughout, IDLE after.
//  3 jalr taken br_pc=0x102, mis_in=1 -> misalign_exc_out 1-cycle pulse, addr=0x102, no redirect.
//  4 kill_in in REDIRECT with ack same cycle -> IDLE next cycle, all control outputs 0, no FLUSH phase.
//  5 reset_in low mid-FLUSH, async -> outputs 0 without clock edge; first branch after release handled normally.
//  6 BR_PERF_EN: 10 branches, 3 mispredicts -> br_cnt_out=10, mispred_cnt_out=3; clr_cnt_in -> 0; CNT_SZ=4 saturates at 15.

Source files
------------

// File: rtl/br_redirect_ctrl_if.sv
// Branch-redirect bundle between EXE/fetch (master) and the redirect controller (slave).
// Latency: none, wires only. BR_PERF_EN adds clr_cnt_in, br_cnt_out and mispred_cnt_out.
// Backpressure: the redirect is a valid/ack handshake and the controller stalls EXE via exe_hold_out.
interface br_redirect_ctrl_if #(
    parameter int PC_SZ  = 32,
    parameter int CNT_SZ = 32
);
    logic             exe_valid_in;
    logic             br_taken_in;
    logic [PC_SZ-1:0] br_pc_in;
    logic [PC_SZ-1:0] no_br_pc_in;
    logic             mis_in;
    logic [PC_SZ-1:0] pred_pc_in;
    logic             kill_in;
    logic             redirect_ack_in;
    logic             redirect_valid_out;
    logic [PC_SZ-1:0] redirect_pc_out;
    logic             flush_out;
    logic             exe_hold_out;
    logic             misalign_exc_out;
    logic [PC_SZ-1:0] misalign_addr_out;
`ifdef BR_PERF_EN
    logic              clr_cnt_in;
    logic [CNT_SZ-1:0] br_cnt_out;
    logic [CNT_SZ-1:0] mispred_cnt_out;
`endif

    // A zero-width counter would make the perf ports meaningless.
    if (CNT_SZ < 1) begin : g_param_chk
        $error("br_redirect_ctrl_if: CNT_SZ must be at least 1");
    end

    modport master (
`ifdef BR_PERF_EN
        output clr_cnt_in,
        input  br_cnt_out, mispred_cnt_out,
`endif
        output exe_valid_in, br_taken_in, br_pc_in, no_br_pc_in, mis_in, pred_pc_in,
        output kill_in, redirect_ack_in,
        input  redirect_valid_out, redirect_pc_out, flush_out, exe_hold_out,
        input  misalign_exc_out, misalign_addr_out
    );

    modport slave (
`ifdef BR_PERF_EN
        input  clr_cnt_in,
        output br_cnt_out, mispred_cnt_out,
`endif
        input  exe_valid_in, br_taken_in, br_pc_in, no_br_pc_in, mis_in, pred_pc_in,
        input  kill_in, redirect_ack_in,
        output redirect_valid_out, redirect_pc_out, flush_out, exe_hold_out,
        output misalign_exc_out, misalign_addr_out
    );
endinterface

// File: rtl/br_redirect_ctrl.sv
// Turns an EXE branch resolution into a held fetch redirect plus an IF/ID flush; misaligned targets raise an exception.
// Latency: 1 cycle from resolution to redirect_valid_out / misalign_exc_out; all outputs are registered.
// Backpressure: redirect held until redirect_ack_in and EXE stalled until IDLE; optional BR_PERF_EN adds perf counters.
module br_redirect_ctrl #(
    parameter int PC_SZ     = 32,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_SZ    = 32
) (
    input  logic              clk_in,
    input  logic              reset_in,
    br_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_FLUSH} state_t;

    // The flush counter is 4 bits wide, so longer flush phases cannot be represented.
    if (FLUSH_CYC < 0 || FLUSH_CYC > 15 || CNT_SZ < 1) begin : g_param_chk
        $error("br_redirect_ctrl: FLUSH_CYC must be 0..15 and CNT_SZ at least 1");
    end

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [PC_SZ-1:0] redirect_pc_q, redirect_pc_d;
    logic [PC_SZ-1:0] misalign_addr_q, misalign_addr_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic             flush_q, flush_d;
    logic             hold_q, hold_d;
    logic             exc_q, exc_d;

    logic [PC_SZ-1:0] actual_pc;
    logic             mispred;
    logic             misalign;
    logic             accept;
    logic             enter_redirect;

    assign actual_pc      = bus.br_taken_in ? bus.br_pc_in : bus.no_br_pc_in;
    assign mispred        = (actual_pc != bus.pred_pc_in);
    assign misalign       = bus.mis_in & bus.br_taken_in;
    // A resolution only counts when the FSM is idle and no kill overrides it.
    assign accept         = (state_q == ST_IDLE) & bus.exe_valid_in & ~bus.kill_in;
    // The exception path takes priority over a redirect for the same instruction.
    assign enter_redirect = accept & mispred & ~misalign;

    // Next-state and registered-output values; kill overrides everything.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        redirect_pc_d   = redirect_pc_q;
        misalign_addr_d = misalign_addr_q;
        exc_d           = 1'b0;
        if (bus.kill_in) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && misalign) begin
                        exc_d           = 1'b1;
                        misalign_addr_d = bus.br_pc_in;
                    end else if (enter_redirect) begin
                        state_d       = ST_REDIRECT;
                        redirect_pc_d = actual_pc;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ack_in) begin
                        if (FLUSH_CYC == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        redirect_valid_d = (state_d == ST_REDIRECT);
        flush_d          = (state_d != ST_IDLE);
        hold_d           = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 4'd0;
            redirect_pc_q    <= '0;
            misalign_addr_q  <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            hold_q           <= 1'b0;
            exc_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_addr_q  <= misalign_addr_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            hold_q           <= hold_d;
            exc_q            <= exc_d;
        end
    end

    assign bus.redirect_valid_out = redirect_valid_q;
    assign bus.redirect_pc_out    = redirect_pc_q;
    assign bus.flush_out          = flush_q;
    assign bus.exe_hold_out       = hold_q;
    assign bus.misalign_exc_out   = exc_q;
    assign bus.misalign_addr_out  = misalign_addr_q;

`ifdef BR_PERF_EN
    logic [CNT_SZ-1:0] br_cnt_q;
    logic [CNT_SZ-1:0] mispred_cnt_q;

    // Saturating perf counters; clear beats increment, and a kill cycle never counts.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (bus.clr_cnt_in) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (accept && !(&br_cnt_q)) begin
                br_cnt_q <= br_cnt_q + CNT_SZ'(1);
            end
            if (enter_redirect && !(&mispred_cnt_q)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_SZ'(1);
            end
        end
    end

    assign bus.br_cnt_out      = br_cnt_q;
    assign bus.mispred_cnt_out = mispred_cnt_q;
`endif
endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Bench for br_redirect_ctrl: directed scenarios plus random traffic against a transaction-level model.
// Latency: model predicts the outputs seen one clock after each input set.
// Backpressure: acks and kills are driven randomly; BR_PERF_EN also exercises the counters with CNT_SZ=4.
module tb_br_redirect_ctrl;
`ifdef BR_PERF_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif
    localparam int FC = 2;

    logic clk_in;
    logic reset_in;

    br_redirect_ctrl_if #(.PC_SZ(32), .CNT_SZ(CW)) bus ();

    br_redirect_ctrl #(.PC_SZ(32), .FLUSH_CYC(FC), .CNT_SZ(CW)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus.slave)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int errors = 0;
    int checks = 0;

    // Model: a pending redirect flag plus the number of flush cycles still owed.
    bit          m_redir;
    int          m_left;
    logic [31:0] m_pc;
    bit          m_exc;
    logic [31:0] m_addr;
    int          m_brc;
    int          m_mpc;
    int          cnt_max;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_redir = 0;
        m_left  = 0;
        m_pc    = '0;
        m_exc   = 0;
        m_addr  = '0;
        m_brc   = 0;
        m_mpc   = 0;
    endtask

    task automatic check_outputs();
        check_eq("redirect_valid", 64'(bus.redirect_valid_out), 64'(m_redir));
        check_eq("redirect_pc", 64'(bus.redirect_pc_out), 64'(m_pc));
        check_eq("flush", 64'(bus.flush_out), 64'(m_redir || m_left > 0));
        check_eq("exe_hold", 64'(bus.exe_hold_out), 64'(m_redir || m_left > 0));
        check_eq("misalign_exc", 64'(bus.misalign_exc_out), 64'(m_exc));
        check_eq("misalign_addr", 64'(bus.misalign_addr_out), 64'(m_addr));
`ifdef BR_PERF_EN
        check_eq("br_cnt", 64'(bus.br_cnt_out), 64'(m_brc));
        check_eq("mispred_cnt", 64'(bus.mispred_cnt_out), 64'(m_mpc));
`endif
    endtask

    // Apply one set of inputs, advance the model by one clock, then compare at the falling edge.
    task automatic drive(input bit v, input bit t, input logic [31:0] br, input logic [31:0] nb,
                         input logic [31:0] pred, input bit mis, input bit kill, input bit ack,
                         input bit clr);
        bit          busy;
        bit          entered;
        logic [31:0] act;
        bus.exe_valid_in    = v;
        bus.br_taken_in     = t;
        bus.br_pc_in        = br;
        bus.no_br_pc_in     = nb;
        bus.pred_pc_in      = pred;
        bus.mis_in          = mis;
        bus.kill_in         = kill;
        bus.redirect_ack_in = ack;
`ifdef BR_PERF_EN
        bus.clr_cnt_in      = clr;
`endif
        busy    = m_redir || m_left > 0;
        entered = 0;
        m_exc   = 0;
        act     = t ? br : nb;
        if (kill) begin
            m_redir = 0;
            m_left  = 0;
        end else if (m_redir) begin
            if (ack) begin
                m_redir = 0;
                m_left  = FC;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (v) begin
            if (mis && t) begin
                m_exc  = 1;
                m_addr = br;
            end else if (act != pred) begin
                m_redir = 1;
                m_pc    = act;
                entered = 1;
            end
        end
        if (clr) begin
            m_brc = 0;
            m_mpc = 0;
        end else begin
            if (!kill && !busy && v) m_brc = (m_brc < cnt_max) ? m_brc + 1 : cnt_max;
            if (entered) m_mpc = (m_mpc < cnt_max) ? m_mpc + 1 : cnt_max;
        end
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic idle_cycle();
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    endtask

    initial begin
        int flush_seen;
        cnt_max = (CW >= 31) ? 32'h7fff_ffff : ((1 << CW) - 1);
        reset_model();
        reset_in = 1'b0;
        bus.exe_valid_in = 0; bus.br_taken_in = 0; bus.br_pc_in = '0; bus.no_br_pc_in = '0;
        bus.pred_pc_in = '0; bus.mis_in = 0; bus.kill_in = 0; bus.redirect_ack_in = 0;
`ifdef BR_PERF_EN
        bus.clr_cnt_in = 0;
`endif
        repeat (2) @(negedge clk_in);
        check_outputs();
        reset_in = 1'b1;

        // Correctly predicted taken branch: nothing happens.
        drive(1, 1, 32'h100, 32'h0f4, 32'h100, 0, 0, 0, 0);
        idle_cycle();

        // Mispredicted taken branch, ack on the third redirect cycle: five flush cycles total.
        flush_seen = 0;
        drive(1, 1, 32'h200, 32'h0f8, 32'h044, 0, 0, 0, 0); flush_seen += int'(bus.flush_out);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);       flush_seen += int'(bus.flush_out);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);       flush_seen += int'(bus.flush_out);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);       flush_seen += int'(bus.flush_out);
        repeat (4) begin
            idle_cycle();
            flush_seen += int'(bus.flush_out);
        end
        check_eq("flush_cycles", 64'(flush_seen), 64'(3 + FC));

        // Misaligned jalr target: one-cycle exception, no redirect.
        drive(1, 1, 32'h102, 32'h008, 32'h104, 1, 0, 0, 0);
        idle_cycle();

        // Kill together with ack while redirecting: straight back to idle.
        drive(1, 0, 32'h300, 32'h010, 32'h300, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 0);
        idle_cycle();

        // Asynchronous reset in the middle of the flush phase.
        drive(1, 1, 32'h400, 32'h020, 32'h024, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
        reset_in = 1'b0;
        #1;
        reset_model();
        check_outputs();
        #1 reset_in = 1'b1;
        drive(1, 1, 32'h500, 32'h030, 32'h034, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
        repeat (3) idle_cycle();

`ifdef BR_PERF_EN
        // Ten accepted branches, three of them mispredicted.
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0 && i < 9) begin
                drive(1, 1, 32'h600, 32'h040, 32'h044, 0, 0, 0, 0);
                drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
                repeat (FC) idle_cycle();
            end else begin
                drive(1, 0, 32'h600, 32'h040, 32'h040, 0, 0, 0, 0);
            end
        end
        check_eq("br_cnt_10", 64'(bus.br_cnt_out), 64'd10);
        check_eq("mispred_cnt_3", 64'(bus.mispred_cnt_out), 64'd3);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
        check_eq("br_cnt_clr", 64'(bus.br_cnt_out), 64'd0);
        for (int i = 0; i < 20; i++) drive(1, 0, 32'h700, 32'h050, 32'h050, 0, 0, 0, 0);
        check_eq("br_cnt_sat", 64'(bus.br_cnt_out), 64'd15);
`endif

        // Random traffic with small PC ranges so predictions often match.
        for (int i = 0; i < 1500; i++) begin
            bit          v, t, mis, kill, ack, clr;
            logic [31:0] br, nb, pred;
            v    = ($urandom_range(0, 2) != 0);
            t    = $urandom_range(0, 1) != 0;
            br   = 32'($urandom_range(0, 15)) << 2;
            nb   = 32'($urandom_range(0, 15)) << 2;
            mis  = ($urandom_range(0, 7) == 0);
            kill = ($urandom_range(0, 15) == 0);
            ack  = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) != 0) pred = t ? br : nb;
            else pred = 32'($urandom_range(0, 15)) << 2;
            if (mis) br = br | 32'h2;
`ifndef BR_PERF_EN
            clr = 0;
`endif
            drive(v, t, br, nb, pred, mis, kill, ack, clr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
